// File: rtl/mem_req_arbiter.sv
// N-way round-robin arbiter merging L1 request streams onto one memory port, one transaction in flight.
// Optional per-requester grant counters are compiled in when MEM_ARB_PERF_EN is defined.
module mem_req_arbiter #(
    parameter int N_REQ = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ-1:0]      req_write,
    input  logic [N_REQ*XLEN-1:0] req_addr,
    input  logic [N_REQ*XLEN-1:0] req_wdata,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [XLEN-1:0]       mem_req_addr,
    output logic [XLEN-1:0]       mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [XLEN-1:0]       mem_rsp_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [N_REQ*32-1:0]   grant_count
`endif
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    // Doubles as the in-flight grant index: the winner is always the last grant.
    logic [GW-1:0]   last_grant_reg;
    logic            issue_write_reg;
    logic [XLEN-1:0] issue_addr_reg;
    logic [XLEN-1:0] issue_wdata_reg;

    logic            win_found;
    logic [GW-1:0]   win_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!win_found && req_valid[(int'(last_grant_reg) + k) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = GW'((int'(last_grant_reg) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_found)     state_next = ISSUE;
            ISSUE:   if (mem_req_ready) state_next = WAIT;
            WAIT:    if (mem_rsp_valid) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            last_grant_reg  <= GW'(N_REQ - 1);
            issue_write_reg <= 1'b0;
            issue_addr_reg  <= '0;
            issue_wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && win_found) begin
                last_grant_reg  <= win_idx;
                issue_write_reg <= req_write[win_idx];
                issue_addr_reg  <= req_addr[int'(win_idx)*XLEN +: XLEN];
                issue_wdata_reg <= req_wdata[int'(win_idx)*XLEN +: XLEN];
            end
        end
    end

    assign mem_req_valid = (state_reg == ISSUE);
    assign mem_req_write = issue_write_reg;
    assign mem_req_addr  = issue_addr_reg;
    assign mem_req_wdata = issue_wdata_reg;
    assign rsp_rdata     = mem_rsp_rdata;

    // Accept strobe only in IDLE; response strobe only in WAIT, so stray responses elsewhere vanish.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : gen_ch
        assign req_ready[gi] = (state_reg == IDLE) && win_found && (win_idx == GW'(gi));
        assign rsp_valid[gi] = (state_reg == WAIT) && mem_rsp_valid && (last_grant_reg == GW'(gi));
    end

`ifdef MEM_ARB_PERF_EN
    for (genvar gi = 0; gi < N_REQ; gi++) begin : gen_perf
        logic [31:0] cnt_reg;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_reg <= '0;
            end else if (req_ready[gi] && cnt_reg != 32'hFFFF_FFFF) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
        assign grant_count[gi*32 +: 32] = cnt_reg;
    end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a 2-way instance for the basic read, a 4-way one for the rest.
module tb_mem_req_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 2-requester instance
    logic [1:0]  a_req_valid, a_req_ready, a_req_write, a_rsp_valid;
    logic [63:0] a_req_addr, a_req_wdata;
    logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_valid, a_mem_ready, a_mem_write, a_mem_rsp_valid;
`ifdef MEM_ARB_PERF_EN
    logic [63:0] a_grant_count;
`endif

    // 4-requester instance
    logic [3:0]   b_req_valid, b_req_ready, b_req_write, b_rsp_valid;
    logic [127:0] b_req_addr, b_req_wdata;
    logic [31:0]  b_rsp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic         b_mem_valid, b_mem_ready, b_mem_write, b_mem_rsp_valid;
`ifdef MEM_ARB_PERF_EN
    logic [127:0] b_grant_count;
`endif

    mem_req_arbiter #(.N_REQ(2), .XLEN(32)) u_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
        .mem_req_valid(a_mem_valid), .mem_req_ready(a_mem_ready), .mem_req_write(a_mem_write),
        .mem_req_addr(a_mem_addr), .mem_req_wdata(a_mem_wdata),
        .mem_rsp_valid(a_mem_rsp_valid), .mem_rsp_rdata(a_mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .grant_count(a_grant_count)
`endif
    );

    mem_req_arbiter #(.N_REQ(4), .XLEN(32)) u_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .mem_req_valid(b_mem_valid), .mem_req_ready(b_mem_ready), .mem_req_write(b_mem_write),
        .mem_req_addr(b_mem_addr), .mem_req_wdata(b_mem_wdata),
        .mem_rsp_valid(b_mem_rsp_valid), .mem_rsp_rdata(b_mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .grant_count(b_grant_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic restore_b_addr();
        for (int i = 0; i < 4; i++) begin
            b_req_addr[i*32 +: 32]  = 32'h1000 + 32'(i * 16);
            b_req_wdata[i*32 +: 32] = 32'hCAFE0000 + 32'(i);
        end
    endtask

    // Full read transaction on the 4-way instance with an immediately ready downstream.
    // Entered and left at posedge+1 with the arbiter in IDLE.
    task automatic b_txn(input logic [3:0] valid, input int exp, input logic [31:0] rdata);
        b_req_valid = valid;
        @(negedge clk);
        chk("rr_req_ready", 64'(b_req_ready), 64'd1 << exp);
        @(posedge clk); #1;
        b_mem_ready = 1'b1;
        @(negedge clk);
        chk("rr_mem_valid", 64'(b_mem_valid), 64'd1);
        chk("rr_mem_addr", 64'(b_mem_addr), 64'(32'h1000 + 32'(exp * 16)));
        chk("rr_no_ready_in_issue", 64'(b_req_ready), 64'd0);
        @(posedge clk); #1;
        b_mem_ready     = 1'b0;
        b_mem_rsp_valid = 1'b1;
        b_mem_rdata     = rdata;
        @(negedge clk);
        chk("rr_rsp_valid", 64'(b_rsp_valid), 64'd1 << exp);
        chk("rr_rsp_rdata", 64'(b_rsp_rdata), 64'(rdata));
        @(posedge clk); #1;
        b_mem_rsp_valid = 1'b0;
        $display("txn b: grant=%0d addr=0x%0h rdata=0x%0h", exp, 32'h1000 + 32'(exp * 16), rdata);
    endtask

    initial begin
        a_req_valid = '0; a_req_write = '0; a_req_addr = '0; a_req_wdata = '0;
        a_mem_ready = 1'b0; a_mem_rsp_valid = 1'b0; a_mem_rdata = '0;
        b_req_valid = '0; b_req_write = '0;
        b_mem_ready = 1'b0; b_mem_rsp_valid = 1'b0; b_mem_rdata = '0;
        restore_b_addr();

        // Reset values
        @(negedge clk);
        chk("rst_a_mem_valid", 64'(a_mem_valid), 64'd0);
        chk("rst_a_rsp_valid", 64'(a_rsp_valid), 64'd0);
        chk("rst_b_req_ready", 64'(b_req_ready), 64'd0);
        chk("rst_b_mem_fields", {31'd0, b_mem_write, b_mem_addr}, 64'd0);
        chk("rst_b_mem_wdata", 64'(b_mem_wdata), 64'd0);
`ifdef MEM_ARB_PERF_EN
        chk("rst_b_grant_count_lo", b_grant_count[63:0], 64'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        // 2-way: requester 0 reads 0x100
        a_req_valid = 2'b01;
        a_req_addr[31:0] = 32'h100;
        @(negedge clk);
        chk("a_req_ready_T", 64'(a_req_ready), 64'd1);
        chk("a_mem_valid_T", 64'(a_mem_valid), 64'd0);
        @(posedge clk); #1;
        a_req_valid = 2'b00;
        a_req_addr[31:0] = 32'h0;
        a_mem_ready = 1'b1;
        @(negedge clk);
        chk("a_mem_valid_T1", 64'(a_mem_valid), 64'd1);
        chk("a_mem_addr_T1", 64'(a_mem_addr), 64'h100);
        chk("a_mem_write_T1", 64'(a_mem_write), 64'd0);
        @(posedge clk); #1;
        a_mem_ready = 1'b0;
        a_mem_rsp_valid = 1'b1;
        a_mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("a_rsp_valid_T2", 64'(a_rsp_valid), 64'd1);
        chk("a_rsp_rdata_T2", 64'(a_rsp_rdata), 64'hDEADBEEF);
        @(posedge clk); #1;
        a_mem_rsp_valid = 1'b0;
        $display("txn a: grant=0 addr=0x100 rdata=0xdeadbeef");
        @(negedge clk);
        chk("a_rsp_valid_after", 64'(a_rsp_valid), 64'd0);
        @(posedge clk); #1;

        // 4-way round robin with everybody requesting
        b_txn(4'b1111, 0, 32'hA0);
        b_txn(4'b1111, 1, 32'hA1);
        b_txn(4'b1111, 2, 32'hA2);
        b_txn(4'b1111, 3, 32'hA3);
        b_txn(4'b1111, 0, 32'hA4);

        // Downstream stall: requester 2 write, fields must hold while inputs churn
        b_req_valid = 4'b0100;
        b_req_write = 4'b0100;
        @(negedge clk);
        chk("stall_accept", 64'(b_req_ready), 64'h4);
        @(posedge clk); #1;
        b_req_valid = 4'b1111;
        b_req_write = 4'b0000;
        b_req_addr[64 +: 32]  = 32'h0BAD;
        b_req_wdata[64 +: 32] = 32'h0BAD;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_valid", 64'(b_mem_valid), 64'd1);
            chk("stall_fields", {b_mem_write, b_mem_addr, b_mem_wdata[30:0]}, {1'b1, 32'h1020, 31'h4AFE0002});
            chk("stall_no_ready", 64'(b_req_ready), 64'd0);
            @(posedge clk); #1;
        end
        b_mem_ready = 1'b1;
        @(posedge clk); #1;
        b_mem_ready = 1'b0;
        b_mem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("stall_rsp", 64'(b_rsp_valid), 64'h4);
        @(posedge clk); #1;
        b_mem_rsp_valid = 1'b0;
        b_req_valid = 4'b0000;
        restore_b_addr();
        $display("txn b: grant=2 write addr=0x1020 after 5 stall cycles");

        // Spurious response in IDLE
        b_mem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("spur_idle_rsp", 64'(b_rsp_valid), 64'd0);
        @(posedge clk); #1;
        b_mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("spur_idle_state", {63'd0, b_mem_valid}, 64'd0);
        @(posedge clk); #1;
        b_txn(4'b1111, 3, 32'hB3);

        // Spurious response in ISSUE
        b_req_valid = 4'b0010;
        @(negedge clk);
        chk("spur_issue_accept", 64'(b_req_ready), 64'h2);
        @(posedge clk); #1;
        b_req_valid = 4'b0000;
        b_mem_rsp_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("spur_issue_rsp", 64'(b_rsp_valid), 64'd0);
            chk("spur_issue_state", 64'(b_mem_valid), 64'd1);
            @(posedge clk); #1;
        end
        b_mem_rsp_valid = 1'b0;
        b_mem_ready = 1'b1;
        @(posedge clk); #1;
        b_mem_ready = 1'b0;
        b_mem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("spur_issue_final_rsp", 64'(b_rsp_valid), 64'h2);
        @(posedge clk); #1;
        b_mem_rsp_valid = 1'b0;
        $display("txn b: grant=1 with spurious responses during issue");

        // Reset while waiting for a response
        b_req_valid = 4'b0100;
        @(posedge clk); #1;
        b_req_valid = 4'b0000;
        b_mem_ready = 1'b1;
        @(posedge clk); #1;
        b_mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_wait_mem_valid", 64'(b_mem_valid), 64'd0);
        chk("rst_wait_mem_addr", 64'(b_mem_addr), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        b_mem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("rst_late_rsp", 64'(b_rsp_valid), 64'd0);
        @(posedge clk); #1;
        b_mem_rsp_valid = 1'b0;
        b_txn(4'b1111, 0, 32'hC0);
        b_req_valid = 4'b0000;

`ifdef MEM_ARB_PERF_EN
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        b_txn(4'b0010, 1, 32'hD1);
        b_txn(4'b0010, 1, 32'hD2);
        b_txn(4'b0010, 1, 32'hD3);
        b_req_valid = 4'b0000;
        chk("perf_count1", 64'(b_grant_count[63:32]), 64'd3);
        chk("perf_count0", 64'(b_grant_count[31:0]), 64'd0);
        force u_b.gen_perf[1].cnt_reg = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release u_b.gen_perf[1].cnt_reg;
        b_txn(4'b0010, 1, 32'hD4);
        b_req_valid = 4'b0000;
        chk("perf_saturate", 64'(b_grant_count[63:32]), 64'hFFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
